sd_sector_arbiter: RTL and testbench
====================================

Name: sd_sector_arbiter

Overview:
- Shares the single SD sector engine (sd_rw sector/byte interface) between NREQ independent requesters, e.g. floppy drive A, floppy drive B and the OSD/MCU image loader.
- Latches per-requester read/write requests with their sector numbers and grants them round-robin.
- Sequences the engine's start/busy/done handshake for each granted request.
- Steers the byte stream to or from the granted requester, and reports completion or error per requester.

Parameters:
- NREQ, 3: number of requesters, 2..8.
- ISSUE_TMO, 4096: clk cycles allowed between asserting a start and the engine raising rbusy.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset; 1 = working, 0 = reset
- req_rd  in  NREQ  per-requester read request pulse
- req_wr  in  NREQ  per-requester write request pulse
- req_sector  in  32*NREQ  sector number, slice i = [32*i+31:32*i], sampled with the request pulse
- req_pending  out  NREQ  request i latched and not yet completed
- req_active  out  NREQ  one-hot, requester currently granted
- req_done  out  NREQ  one-cycle completion pulse
- req_err  out  NREQ  valid with req_done; 1 = failed
- req_outen  out  NREQ  engine outen, gated to the granted requester
- req_inen  out  NREQ  engine inen, gated to the granted requester
- req_addr  out  9  engine outaddr, broadcast
- req_outbyte  out  8  engine outbyte, broadcast
- req_inbyte  in  8*NREQ  write data per requester
- sd_rstart  out  1  to engine rstart
- sd_wstart  out  1  to engine wstart
- sd_sector  out  32  to engine sector
- sd_rbusy  in  1  from engine rbusy
- sd_rdone  in  1  from engine rdone
- sd_outen  in  1  from engine outen
- sd_inen  in  1  from engine inen
- sd_outaddr  in  9  from engine outaddr
- sd_outbyte  in  8  from engine outbyte
- sd_inbyte  out  8  to engine inbyte: mux of req_inbyte by grant

Behaviour:
- Reset values: all outputs 0, pending and direction bits cleared, state IDLE, round-robin pointer 0.
- Asserting reset mid-transfer drops sd_rstart/sd_wstart immediately. No req_done is emitted.
- Latching: on req_rd[i] or req_wr[i] with pending[i] = 0, set pending[i], store the direction (write = req_wr[i] & ~req_rd[i]; read wins if both) and store the sector.
  - A request while pending[i] = 1 is ignored; the stored sector is unchanged.
  - A request in the same cycle as req_done[i] is accepted as a new request.
- FSM states:
  - IDLE: wait until sd_rbusy = 0, which means the card is initialised and READY. Grant the first pending requester at or after the pointer, wrapping modulo NREQ. Set req_active, load sd_sector. Go to ISSUE on the next cycle.
  - ISSUE: hold sd_rstart (read) or sd_wstart (write) high and sd_sector stable until sd_rbusy = 1, then drop the start and go to XFER. If ISSUE_TMO cycles elapse first, complete with err = 1.
  - XFER: clear done_seen on entry. Set done_seen when sd_rdone = 1. On sd_rbusy 1 -> 0, go to COMPLETE.
  - COMPLETE, one cycle: req_done[g] = 1 and req_err[g] = ~done_seen (a write that times out in the engine returns to READY without rdone). Clear pending[g] and req_active. Pointer = (g+1) mod NREQ. Go to IDLE.
- Data steering:
  - Combinational from the engine; zero added latency: req_outen[g] = sd_outen, req_inen[g] = sd_inen.
  - sd_inbyte = req_inbyte slice g, zero when no grant.
  - Ungranted requesters see outen/inen = 0.
- Fairness: a requester re-requesting immediately waits behind all other pending requesters.
- Minimum gap between two transfers: 1 IDLE cycle.
- The engine's internal read retries are invisible to the arbiter; sd_rbusy stays high throughout.

Decomposition:
- Package sd_arb_pkg:
  - State encoding IDLE/ISSUE/XFER/COMPLETE (2 bits).
  - Timeout counter width, clog2(ISSUE_TMO)+1.
  - Sector width 32 and byte-address width 9 constants.
- Sub-module sd_rr_pick (combinational): inputs pending[NREQ] and ptr; outputs valid and one-hot/index grant.

Test Plan:
- Single read: after init (rbusy 1 -> 0), req_rd[1] with sector 0x00000123 -> sd_sector = 0x123 and sd_rstart held until rbusy rises. Requester 1 receives 512 outen pulses with addr 0..511; all other outen stay 0. req_done[1] = 1, req_err[1] = 0.
- Contention: req_rd[0], req_wr[1], req_rd[2] in the same cycle with pointer 0 -> grants in order 0, 1, 2. A second req_rd[0] issued during requester 2's transfer is served after 2. sd_wstart is asserted only for grant 1.
- Write data path: grant requester 2 with req_inbyte slice 2 = 0xA5 and other slices 0x00 -> sd_inbyte = 0xA5 for every sd_inen. req_inen[2] mirrors sd_inen.
- Write error: engine model returns rbusy to 0 without an rdone pulse -> req_done[g] = 1 and req_err[g] = 1; the arbiter returns to IDLE and serves the next pending request.
- Issue timeout: model keeps rbusy = 0 and ignores the start -> after 4096 cycles req_done = 1 and req_err = 1, and sd_rstart drops.
- Reset and duplicates: assert rstn = 0 during XFER -> all outputs 0 and pending cleared. After reset release, a duplicate req_rd[0] while pending[0] = 1 keeps the first sector.

Source files
------------

// File: rtl/sd_sector_arbiter_pkg.sv
// Shared constants for the SD sector arbiter: FSM encoding, bus widths and
// width helpers for the round-robin pointer and the issue timeout counter.
package sd_arb_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_XFER     = 2'd2;
    localparam logic [1:0] ST_COMPLETE = 2'd3;

    localparam int SECTOR_W = 32;
    localparam int ADDR_W   = 9;
    localparam int BYTE_W   = 8;

    // One extra bit so the terminal count ISSUE_TMO-1 always fits.
    function automatic int tmo_cnt_w(input int tmo);
        return $clog2(tmo) + 1;
    endfunction

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_sector_arbiter_if.sv
// Engine-side bus of the arbiter: start/busy/done handshake, sector number
// and the byte stream of the sd_rw sector engine.
interface sd_sector_arbiter_if;
    import sd_arb_pkg::*;

    logic                  sd_rstart;
    logic                  sd_wstart;
    logic [SECTOR_W-1:0]   sd_sector;
    logic                  sd_rbusy;
    logic                  sd_rdone;
    logic                  sd_outen;
    logic                  sd_inen;
    logic [ADDR_W-1:0]     sd_outaddr;
    logic [BYTE_W-1:0]     sd_outbyte;
    logic [BYTE_W-1:0]     sd_inbyte;

    modport master (
        output sd_rstart, sd_wstart, sd_sector, sd_inbyte,
        input  sd_rbusy, sd_rdone, sd_outen, sd_inen, sd_outaddr, sd_outbyte
    );

    modport slave (
        input  sd_rstart, sd_wstart, sd_sector, sd_inbyte,
        output sd_rbusy, sd_rdone, sd_outen, sd_inen, sd_outaddr, sd_outbyte
    );

endinterface

// File: rtl/sd_sector_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending requester at or after ptr,
// wrapping modulo NREQ.
module sd_rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int PTR_W = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0]  pending,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [NREQ-1:0]  grant_oh,
    output logic [PTR_W-1:0] grant_idx
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        valid     = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NREQ)) begin
                sum = sum - (PTR_W+1)'(NREQ);
            end
            idx = sum[PTR_W-1:0];
            if (!valid && pending[idx]) begin
                valid     = 1'b1;
                grant_idx = idx;
            end
        end
        if (valid) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares one SD sector engine between NREQ requesters: latches requests,
// grants them round-robin, runs the start/busy/done handshake, steers bytes.
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int ISSUE_TMO = 4096
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_rd,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [SECTOR_W*NREQ-1:0] req_sector,
    output logic [NREQ-1:0]          req_pending,
    output logic [NREQ-1:0]          req_active,
    output logic [NREQ-1:0]          req_done,
    output logic [NREQ-1:0]          req_err,
    output logic [NREQ-1:0]          req_outen,
    output logic [NREQ-1:0]          req_inen,
    output logic [ADDR_W-1:0]        req_addr,
    output logic [BYTE_W-1:0]        req_outbyte,
    input  logic [BYTE_W*NREQ-1:0]   req_inbyte,
    sd_sector_arbiter_if.master      sd_bus
);

    localparam int PTR_W = ptr_w(NREQ);
    localparam int TMO_W = tmo_cnt_w(ISSUE_TMO);

    logic [1:0]          state;
    logic [NREQ-1:0]     pending;
    logic [NREQ-1:0]     dir_wr;
    logic [SECTOR_W-1:0] sector_mem [NREQ];
    logic [NREQ-1:0]     active;
    logic [PTR_W-1:0]    gidx;
    logic [PTR_W-1:0]    ptr;
    logic                wr_cur;
    logic                done_seen;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [SECTOR_W-1:0] sector_q;

    logic                pick_valid;
    logic [NREQ-1:0]     pick_oh;
    logic [PTR_W-1:0]    pick_idx;
    logic [NREQ-1:0]     accept;
    logic                in_complete;

    sd_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .pending   (pending),
        .ptr       (ptr),
        .valid     (pick_valid),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx)
    );

    assign in_complete = (state == ST_COMPLETE);

    // A request in the completion cycle of the same requester is a new one.
    assign accept = (req_rd | req_wr) & (~pending | req_done);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= '0;
            dir_wr  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i]) begin
                    pending[i] <= 1'b1;
                    dir_wr[i]  <= req_wr[i] & ~req_rd[i];
                end else if (req_done[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                sector_mem[i] <= req_sector[SECTOR_W*i +: SECTOR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            active    <= '0;
            gidx      <= '0;
            ptr       <= '0;
            wr_cur    <= 1'b0;
            done_seen <= 1'b0;
            tmo_cnt   <= '0;
            sector_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // rbusy low in IDLE means the card is initialised and ready
                    if (!sd_bus.sd_rbusy && pick_valid) begin
                        active    <= pick_oh;
                        gidx      <= pick_idx;
                        wr_cur    <= dir_wr[pick_idx];
                        sector_q  <= sector_mem[pick_idx];
                        tmo_cnt   <= '0;
                        done_seen <= 1'b0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sd_bus.sd_rbusy) begin
                        done_seen <= 1'b0;
                        state     <= ST_XFER;
                    end else if (tmo_cnt == TMO_W'(ISSUE_TMO - 1)) begin
                        state <= ST_COMPLETE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (sd_bus.sd_rdone) begin
                        done_seen <= 1'b1;
                    end
                    if (!sd_bus.sd_rbusy) begin
                        state <= ST_COMPLETE;
                    end
                end
                default: begin
                    active <= '0;
                    ptr    <= (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_pending = pending;
    assign req_active  = active;
    assign req_done    = in_complete ? active : '0;
    // Engine write timeouts return to ready without rdone, hence ~done_seen.
    assign req_err     = (in_complete && !done_seen) ? active : '0;

    assign sd_bus.sd_rstart = (state == ST_ISSUE) && !wr_cur;
    assign sd_bus.sd_wstart = (state == ST_ISSUE) && wr_cur;
    assign sd_bus.sd_sector = sector_q;

    assign req_outen   = sd_bus.sd_outen ? active : '0;
    assign req_inen    = sd_bus.sd_inen  ? active : '0;
    assign req_addr    = sd_bus.sd_outaddr;
    assign req_outbyte = sd_bus.sd_outbyte;
    assign sd_bus.sd_inbyte = (|active) ? req_inbyte[BYTE_W*gidx +: BYTE_W] : '0;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter with a small scripted engine model.
module tb_sd_sector_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  req_rd, req_wr;
    logic [95:0] req_sector;
    logic [23:0] req_inbyte;
    logic [2:0]  req_pending, req_active, req_done, req_err, req_outen, req_inen;
    logic [8:0]  req_addr;
    logic [7:0]  req_outbyte;

    sd_sector_arbiter_if sd_bus ();

    sd_sector_arbiter #(.NREQ(3), .ISSUE_TMO(4096)) dut (
        .clk(clk), .rstn(rstn),
        .req_rd(req_rd), .req_wr(req_wr), .req_sector(req_sector),
        .req_pending(req_pending), .req_active(req_active),
        .req_done(req_done), .req_err(req_err),
        .req_outen(req_outen), .req_inen(req_inen),
        .req_addr(req_addr), .req_outbyte(req_outbyte),
        .req_inbyte(req_inbyte), .sd_bus(sd_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // monitor statistics
    logic        clr_stats;
    int          oe_cnt [3];
    int          ie_cnt [3];
    int          done_cnt [3];
    int          err_cnt [3];
    int          addr_bad, inb_bad, stray;
    logic [2:0]  wmask;
    logic [8:0]  exp_addr;
    logic [7:0]  exp_inbyte;
    int          done_order [$];

    // engine model bookkeeping
    logic [31:0] start_sec [$];
    bit          start_wr [$];
    bit          hold_bad;

    always @(negedge clk) begin
        if (clr_stats) begin
            for (int i = 0; i < 3; i++) begin
                oe_cnt[i] = 0; ie_cnt[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0;
            end
            addr_bad = 0; inb_bad = 0; stray = 0; wmask = '0; exp_addr = '0;
            done_order.delete();
        end else begin
            if (sd_bus.sd_outen) begin
                for (int i = 0; i < 3; i++) if (req_outen[i]) oe_cnt[i]++;
                if (req_addr !== exp_addr || req_outbyte !== exp_addr[7:0]) addr_bad++;
                exp_addr = exp_addr + 9'd1;
            end else if (req_outen != 3'b000) stray++;
            if (sd_bus.sd_inen) begin
                for (int i = 0; i < 3; i++) if (req_inen[i]) ie_cnt[i]++;
                if (sd_bus.sd_inbyte !== exp_inbyte) inb_bad++;
            end else if (req_inen != 3'b000) stray++;
            if (!sd_bus.sd_rbusy) exp_addr = '0;
            if (sd_bus.sd_wstart) wmask = wmask | req_active;
            for (int i = 0; i < 3; i++) begin
                if (req_done[i]) begin
                    done_cnt[i]++;
                    if (req_err[i]) err_cnt[i]++;
                    done_order.push_back(i);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        clr_stats = 1'b1;
        @(negedge clk);
        #1;
        clr_stats = 1'b0;
        start_sec.delete();
        start_wr.delete();
    endtask

    task automatic pulse_req(input logic [2:0] rd, input logic [2:0] wr);
        req_rd = rd;
        req_wr = wr;
        cyc();
        req_rd = '0;
        req_wr = '0;
    endtask

    task automatic set_sector(input int i, input logic [31:0] sec);
        req_sector[32*i +: 32] = sec;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        sd_bus.sd_rbusy = 1'b1;
        sd_bus.sd_outen = 1'b0;
        sd_bus.sd_inen  = 1'b0;
        sd_bus.sd_rdone = 1'b0;
        repeat (3) cyc();
        rstn = 1'b1;
        repeat (2) cyc();
        sd_bus.sd_rbusy = 1'b0;
        cyc();
    endtask

    // Scripted engine: waits for a start, holds it 2 cycles, raises rbusy,
    // moves n bytes, optionally pulses rdone, drops rbusy.
    task automatic engine_serve(input int n, input bit give_done,
                                input logic [2:0] rereq, output bit ok);
        logic [31:0] sec0;
        bit          w0;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (sd_bus.sd_rstart || sd_bus.sd_wstart) break;
            cyc();
        end
        if (!(sd_bus.sd_rstart || sd_bus.sd_wstart)) return;
        sec0 = sd_bus.sd_sector;
        w0   = sd_bus.sd_wstart;
        start_sec.push_back(sec0);
        start_wr.push_back(w0);
        repeat (2) begin
            cyc();
            if (sd_bus.sd_wstart !== w0 || sd_bus.sd_rstart !== !w0 ||
                sd_bus.sd_sector !== sec0) hold_bad = 1'b1;
        end
        sd_bus.sd_rbusy = 1'b1;
        cyc();
        if (sd_bus.sd_rstart || sd_bus.sd_wstart) hold_bad = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (w0) sd_bus.sd_inen = 1'b1;
            else begin
                sd_bus.sd_outen    = 1'b1;
                sd_bus.sd_outaddr  = 9'(k);
                sd_bus.sd_outbyte  = 8'(k);
            end
            cyc();
        end
        sd_bus.sd_outen = 1'b0;
        sd_bus.sd_inen  = 1'b0;
        if (give_done) begin
            sd_bus.sd_rdone = 1'b1;
            cyc();
            sd_bus.sd_rdone = 1'b0;
        end
        sd_bus.sd_rbusy = 1'b0;
        cyc();
        req_rd = rereq;
        cyc();
        req_rd = '0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_inbyte = 24'hFFFFFF;
        #3;
        checks++;
        if ({req_pending, req_active, req_done, req_err, req_outen, req_inen,
             sd_bus.sd_rstart, sd_bus.sd_wstart, sd_bus.sd_sector, sd_bus.sd_inbyte} !== '0)
        begin
            errors++;
            $display("FAIL reset_outputs got pend=%b act=%b done=%b st=%b sec=%h inb=%h exp all 0",
                     req_pending, req_active, req_done, sd_bus.sd_rstart,
                     sd_bus.sd_sector, sd_bus.sd_inbyte);
        end
        repeat (2) cyc();
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_single_read();
        bit ok;
        clear();
        set_sector(1, 32'h00000123);
        pulse_req(3'b010, 3'b000);
        repeat (4) cyc();
        checks++;
        if (req_pending !== 3'b010 || req_active !== 3'b000 || sd_bus.sd_rstart !== 1'b0) begin
            errors++;
            $display("FAIL rd_wait_init got pend=%b act=%b rstart=%b exp 010 000 0",
                     req_pending, req_active, sd_bus.sd_rstart);
        end
        sd_bus.sd_rbusy = 1'b0;
        hold_bad = 1'b0;
        engine_serve(512, 1'b1, 3'b000, ok);
        checks++;
        if (!ok || start_sec.size() != 1) begin
            errors++; $display("FAIL rd_start got ok=%0d starts=%0d exp 1 1", ok, start_sec.size());
        end else begin
            checks++;
            if (start_sec[0] !== 32'h123 || start_wr[0] !== 1'b0) begin
                errors++; $display("FAIL rd_sector got %h wr=%0d exp 00000123 0", start_sec[0], start_wr[0]);
            end
        end
        checks++;
        if (hold_bad) begin errors++; $display("FAIL rd_start_hold got unstable exp held until rbusy"); end
        checks++;
        if (oe_cnt[1] !== 512 || oe_cnt[0] !== 0 || oe_cnt[2] !== 0 || stray !== 0) begin
            errors++;
            $display("FAIL rd_outen got %0d/%0d/%0d stray=%0d exp 0/512/0 0",
                     oe_cnt[0], oe_cnt[1], oe_cnt[2], stray);
        end
        checks++;
        if (addr_bad !== 0) begin errors++; $display("FAIL rd_addr got %0d bad exp 0", addr_bad); end
        checks++;
        if (done_cnt[1] !== 1 || err_cnt[1] !== 0 || req_pending !== 3'b000) begin
            errors++;
            $display("FAIL rd_done got done=%0d err=%0d pend=%b exp 1 0 000",
                     done_cnt[1], err_cnt[1], req_pending);
        end
    endtask

    task automatic test_contention();
        bit ok0, ok1, ok2, ok3;
        do_reset();
        clear();
        set_sector(0, 32'h10); set_sector(1, 32'h11); set_sector(2, 32'h12);
        pulse_req(3'b101, 3'b010);
        engine_serve(4, 1'b1, 3'b000, ok0);
        engine_serve(4, 1'b1, 3'b000, ok1);
        fork
            engine_serve(8, 1'b1, 3'b000, ok2);
            begin
                repeat (6) cyc();
                set_sector(0, 32'h20);
                pulse_req(3'b001, 3'b000);
            end
        join
        engine_serve(4, 1'b1, 3'b000, ok3);
        checks++;
        if (!(ok0 && ok1 && ok2 && ok3) || done_order.size() != 4 ||
            done_order[0] != 0 || done_order[1] != 1 || done_order[2] != 2 || done_order[3] != 0)
        begin
            errors++;
            $display("FAIL cont_order got n=%0d %0d,%0d,%0d,%0d exp 4 0,1,2,0", done_order.size(),
                     done_order[0], done_order[1], done_order[2], done_order[3]);
        end
        checks++;
        if (start_sec.size() != 4 || start_sec[0] !== 32'h10 || start_sec[1] !== 32'h11 ||
            start_sec[2] !== 32'h12 || start_sec[3] !== 32'h20) begin
            errors++;
            $display("FAIL cont_sectors got n=%0d %h %h %h %h exp 10 11 12 20", start_sec.size(),
                     start_sec[0], start_sec[1], start_sec[2], start_sec[3]);
        end
        checks++;
        if (wmask !== 3'b010 || err_cnt[0] + err_cnt[1] + err_cnt[2] !== 0) begin
            errors++;
            $display("FAIL cont_wstart got wmask=%b errs=%0d exp 010 0", wmask,
                     err_cnt[0] + err_cnt[1] + err_cnt[2]);
        end
    endtask

    task automatic test_write_data();
        bit ok;
        clear();
        exp_inbyte = 8'hA5;
        req_inbyte = {8'hA5, 8'h00, 8'h00};
        cyc();
        checks++;
        if (sd_bus.sd_inbyte !== 8'h00) begin
            errors++; $display("FAIL wr_inbyte_idle got %h exp 00", sd_bus.sd_inbyte);
        end
        set_sector(2, 32'h55);
        pulse_req(3'b000, 3'b100);
        engine_serve(16, 1'b1, 3'b000, ok);
        checks++;
        if (!ok || ie_cnt[2] !== 16 || ie_cnt[0] !== 0 || ie_cnt[1] !== 0 || stray !== 0) begin
            errors++;
            $display("FAIL wr_inen got ok=%0d %0d/%0d/%0d stray=%0d exp 1 0/0/16 0",
                     ok, ie_cnt[0], ie_cnt[1], ie_cnt[2], stray);
        end
        checks++;
        if (inb_bad !== 0 || wmask !== 3'b100) begin
            errors++; $display("FAIL wr_inbyte got bad=%0d wmask=%b exp 0 100", inb_bad, wmask);
        end
        checks++;
        if (done_cnt[2] !== 1 || err_cnt[2] !== 0) begin
            errors++; $display("FAIL wr_done got done=%0d err=%0d exp 1 0", done_cnt[2], err_cnt[2]);
        end
    endtask

    task automatic test_write_error();
        bit ok0, ok1;
        clear();
        set_sector(0, 32'h30); set_sector(1, 32'h31);
        pulse_req(3'b010, 3'b001);
        engine_serve(4, 1'b0, 3'b000, ok0);
        engine_serve(4, 1'b1, 3'b000, ok1);
        checks++;
        if (!(ok0 && ok1) || done_order.size() != 2 || done_order[0] != 0 || done_order[1] != 1) begin
            errors++;
            $display("FAIL werr_order got n=%0d %0d,%0d exp 2 0,1", done_order.size(),
                     done_order[0], done_order[1]);
        end
        checks++;
        if (err_cnt[0] !== 1 || err_cnt[1] !== 0 || done_cnt[1] !== 1) begin
            errors++;
            $display("FAIL werr_flags got err0=%0d err1=%0d done1=%0d exp 1 0 1",
                     err_cnt[0], err_cnt[1], done_cnt[1]);
        end
    endtask

    task automatic test_issue_timeout();
        int cnt;
        clear();
        set_sector(2, 32'h40);
        pulse_req(3'b100, 3'b000);
        for (int k = 0; k < 20; k++) begin
            if (sd_bus.sd_rstart) break;
            cyc();
        end
        cnt = 0;
        while (!req_done[2] && cnt < 5000) begin
            cyc();
            cnt++;
        end
        checks++;
        if (cnt !== 4096) begin errors++; $display("FAIL tmo_cycles got %0d exp 4096", cnt); end
        checks++;
        if (req_err[2] !== 1'b1 || sd_bus.sd_rstart !== 1'b0) begin
            errors++; $display("FAIL tmo_err got err=%b rstart=%b exp 1 0", req_err[2], sd_bus.sd_rstart);
        end
        cyc();
        checks++;
        if (req_pending !== 3'b000 || req_active !== 3'b000) begin
            errors++; $display("FAIL tmo_clear got pend=%b act=%b exp 000 000", req_pending, req_active);
        end
    endtask

    task automatic test_reset_dup();
        bit ok;
        clear();
        set_sector(1, 32'h50);
        pulse_req(3'b010, 3'b000);
        for (int k = 0; k < 20; k++) begin
            if (sd_bus.sd_rstart) break;
            cyc();
        end
        sd_bus.sd_rbusy = 1'b1;
        cyc();
        sd_bus.sd_outen = 1'b1;
        sd_bus.sd_outaddr = 9'd0;
        repeat (2) cyc();
        checks++;
        if (req_active !== 3'b010 || req_outen !== 3'b010) begin
            errors++; $display("FAIL rst_pre got act=%b outen=%b exp 010 010", req_active, req_outen);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({req_pending, req_active, req_done, req_err, req_outen, req_inen,
             sd_bus.sd_rstart, sd_bus.sd_wstart, sd_bus.sd_sector} !== '0) begin
            errors++;
            $display("FAIL rst_mid got pend=%b act=%b outen=%b sec=%h exp all 0",
                     req_pending, req_active, req_outen, sd_bus.sd_sector);
        end
        sd_bus.sd_outen = 1'b0;
        repeat (2) cyc();
        rstn = 1'b1;
        cyc();
        checks++;
        if (done_cnt[1] !== 0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", done_cnt[1]); end
        set_sector(0, 32'hAAA);
        pulse_req(3'b001, 3'b000);
        set_sector(0, 32'hBBB);
        pulse_req(3'b001, 3'b000);
        checks++;
        if (req_pending !== 3'b001) begin errors++; $display("FAIL dup_pend got %b exp 001", req_pending); end
        sd_bus.sd_rbusy = 1'b0;
        engine_serve(2, 1'b1, 3'b000, ok);
        checks++;
        if (!ok || start_sec.size() != 1 || start_sec[0] !== 32'hAAA || done_cnt[0] !== 1) begin
            errors++;
            $display("FAIL dup_sector got ok=%0d sec=%h done=%0d exp 1 00000aaa 1",
                     ok, start_sec[0], done_cnt[0]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok0, ok1, ok2;
        clear();
        set_sector(1, 32'h60); set_sector(2, 32'h61);
        pulse_req(3'b110, 3'b000);
        set_sector(1, 32'h62);
        engine_serve(3, 1'b1, 3'b010, ok0);
        engine_serve(3, 1'b1, 3'b000, ok1);
        engine_serve(3, 1'b1, 3'b000, ok2);
        checks++;
        if (!(ok0 && ok1 && ok2) || done_order.size() != 3 ||
            done_order[0] != 1 || done_order[1] != 2 || done_order[2] != 1) begin
            errors++;
            $display("FAIL b2b_order got n=%0d %0d,%0d,%0d exp 3 1,2,1", done_order.size(),
                     done_order[0], done_order[1], done_order[2]);
        end
        checks++;
        if (start_sec.size() != 3 || start_sec[0] !== 32'h60 || start_sec[1] !== 32'h61 ||
            start_sec[2] !== 32'h62) begin
            errors++;
            $display("FAIL b2b_sectors got %h %h %h exp 60 61 62",
                     start_sec[0], start_sec[1], start_sec[2]);
        end
    endtask

    initial begin
        rstn = 1'b0;
        clr_stats = 1'b0;
        req_rd = '0; req_wr = '0;
        req_sector = '0; req_inbyte = '0;
        exp_inbyte = '0;
        hold_bad = 1'b0;
        sd_bus.sd_rbusy = 1'b1; sd_bus.sd_rdone = 1'b0;
        sd_bus.sd_outen = 1'b0; sd_bus.sd_inen = 1'b0;
        sd_bus.sd_outaddr = '0; sd_bus.sd_outbyte = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_write_data();
        test_write_error();
        test_issue_timeout();
        test_reset_dup();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
